// File: rtl/clk_en_gen_if.sv
// Config handshake bundle for clk_en_gen.
//   cfg_valid  master->slave  config request
//   cfg_ready  slave->master  request can be accepted this cycle
//   cfg_ch     master->slave  target channel index
//   cfg_inc    master->slave  new increment for the target channel
//   cfg_err    slave->master  one-cycle pulse after an out-of-range channel transfer
interface clk_en_gen_if #(
    parameter int ACC_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [3:0]       cfg_ch;
    logic [ACC_W-1:0] cfg_inc;
    logic             cfg_err;

    modport master (output cfg_valid, cfg_ch, cfg_inc, input  cfg_ready, cfg_err);
    modport slave  (input  cfg_valid, cfg_ch, cfg_inc, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator.
// Each channel is a phase accumulator; the carry out of the add becomes a one-cycle
// tick and toggles a square wave. A post-reset lock counter holds all channels idle
// for LOCK_CYCLES cycles; increments are reprogrammed through a valid/ready handshake.
//   clk      system clock
//   rst      synchronous reset, active-high
//   ch_en    per-channel run enable
//   cfg      config handshake (slave side)
//   locked   lock sequence complete, channels running
//   tick     per-channel one-cycle enable pulse
//   clk_div  per-channel square wave, toggles on each tick

// One accumulator channel.
//   run_i       channels allowed to accumulate (locked)
//   en_i        channel enable
//   load_i      config transfer targeting this channel
//   load_inc_i  increment to load
//   tick_o      carry pulse
//   div_o       square wave
module clk_en_gen_ch #(
    parameter int               ACC_W       = 16,
    parameter logic [ACC_W-1:0] DEFAULT_INC = 16'h8000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [ACC_W-1:0] load_inc_i,
    output logic             tick_o,
    output logic             div_o
);
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] inc_q;
    logic             tick_q;
    logic             div_q;
    logic [ACC_W:0]   sum_d;

    // Extra top bit of the sum is the wrap carry.
    assign sum_d = {1'b0, acc_q} + {1'b0, inc_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            inc_q  <= DEFAULT_INC;
            tick_q <= 1'b0;
            div_q  <= 1'b0;
        end else if (load_i) begin
            // New increment restarts phase; the add of this cycle is dropped.
            inc_q  <= load_inc_i;
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else if (run_i && en_i) begin
            acc_q  <= sum_d[ACC_W-1:0];
            tick_q <= sum_d[ACC_W];
            div_q  <= div_q ^ sum_d[ACC_W];
        end else begin
            // Disabled or still locking: phase and square wave hold.
            tick_q <= 1'b0;
        end
    end

    assign tick_o = tick_q;
    assign div_o  = div_q;
endmodule

module clk_en_gen #(
    parameter int               NUM_CH      = 2,
    parameter int               ACC_W       = 16,
    parameter int               LOCK_CYCLES = 16,
    parameter logic [ACC_W-1:0] DEFAULT_INC = 16'h8000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  ch_en,
    clk_en_gen_if.slave        cfg,
    output logic               locked,
    output logic [NUM_CH-1:0]  tick,
    output logic [NUM_CH-1:0]  clk_div
);
    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic {S_LOCK, S_RUN} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] lock_cnt_q;
    logic             locked_q;
    logic             cfg_ready_q;
    logic             cfg_err_q;
    logic             xfer;
    logic             ch_ok;
    logic [NUM_CH-1:0] load;

    assign xfer  = cfg.cfg_valid & cfg_ready_q;
    assign ch_ok = (int'(cfg.cfg_ch) < NUM_CH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOCK;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            // Ready drops for exactly the cycle after each transfer.
            cfg_ready_q <= ~xfer;
            cfg_err_q   <= xfer & ~ch_ok;
            case (state_q)
                S_LOCK: begin
                    if (lock_cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                        state_q  <= S_RUN;
                        locked_q <= 1'b1;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    locked_q <= 1'b1;
                end
                default: begin
                    state_q <= S_LOCK;
                end
            endcase
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg.cfg_err   = cfg_err_q;
    assign locked        = locked_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = xfer && (cfg.cfg_ch == 4'(i));

        clk_en_gen_ch #(
            .ACC_W       (ACC_W),
            .DEFAULT_INC (DEFAULT_INC)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .run_i      (locked_q),
            .en_i       (ch_en[i]),
            .load_i     (load[i]),
            .load_inc_i (cfg.cfg_inc),
            .tick_o     (tick[i]),
            .div_o      (clk_div[i])
        );
    end
endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen (NUM_CH=2, ACC_W=16, LOCK_CYCLES=16, DEFAULT_INC=8000).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// n = edges since locked rose (locked visible at n=0).
module tb_clk_en_gen;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ch_en;
    logic       locked;
    logic [1:0] tick;
    logic [1:0] clk_div;
    int         errors = 0;
    int         checks = 0;

    clk_en_gen_if #(.ACC_W(16)) cfg_bus ();

    clk_en_gen #(
        .NUM_CH(2), .ACC_W(16), .LOCK_CYCLES(16), .DEFAULT_INC(16'h8000)
    ) dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .cfg(cfg_bus),
        .locked(locked), .tick(tick), .clk_div(clk_div)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset for 3 cycles and wait out the 16-edge lock sequence (no checks).
    task automatic relock();
        rst = 1'b1; ch_en = 2'b11;
        cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_ch = 4'd0; cfg_bus.cfg_inc = 16'h0;
        repeat (3) step();
        rst = 1'b0;
        repeat (16) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; ch_en = 2'b11;
        cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_ch = 4'd0; cfg_bus.cfg_inc = 16'h0;
        repeat (3) step();
        checks++;
        if ({locked, tick, clk_div, cfg_bus.cfg_ready, cfg_bus.cfg_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state: got %b expected 0000000",
                     {locked, tick, clk_div, cfg_bus.cfg_ready, cfg_bus.cfg_err});
        end
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (locked !== (k == 16)) begin
                errors++;
                $display("FAIL lock_edge k=%0d: locked=%b expected %b", k, locked, k == 16);
            end
            checks++;
            if ({tick, clk_div} !== 4'b0) begin
                errors++;
                $display("FAIL lock_idle k=%0d: tick/div=%b expected 0000", k, {tick, clk_div});
            end
        end
        // Default increment 8000: tick every 2nd edge, divider period 4.
        for (int n = 1; n <= 8; n++) begin
            step();
            checks++;
            if (tick !== {2{n % 2 == 0}}) begin
                errors++;
                $display("FAIL default_tick n=%0d: got %b expected %b", n, tick, {2{n % 2 == 0}});
            end
            checks++;
            if (clk_div !== {2{((n >> 1) & 1) == 1}}) begin
                errors++;
                $display("FAIL default_div n=%0d: got %b expected %b", n, clk_div,
                         {2{((n >> 1) & 1) == 1}});
            end
        end
    endtask

    task automatic test_cfg_rate();
        relock();
        repeat (4) step();
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_ch = 4'd0; cfg_bus.cfg_inc = 16'h4000;
        step();  // n=5: transfer edge
        cfg_bus.cfg_valid = 1'b0;
        checks++;
        if ({cfg_bus.cfg_ready, tick[0], clk_div[0]} !== 3'b000) begin
            errors++;
            $display("FAIL cfg_xfer: ready/tick0/div0=%b expected 000",
                     {cfg_bus.cfg_ready, tick[0], clk_div[0]});
        end
        for (int m = 1; m <= 12; m++) begin
            step();
            checks++;
            if (cfg_bus.cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL cfg_ready_back m=%0d: got %b expected 1", m, cfg_bus.cfg_ready);
            end
            checks++;
            if ({tick, clk_div[0]} !== {(5 + m) % 2 == 0, m % 4 == 0, ((m >> 2) & 1) == 1}) begin
                errors++;
                $display("FAIL inc4000 m=%0d: tick/div0=%b expected %b", m, {tick, clk_div[0]},
                         {(5 + m) % 2 == 0, m % 4 == 0, ((m >> 2) & 1) == 1});
            end
        end
    endtask

    task automatic test_fraction();
        int cnt;
        relock();
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_ch = 4'd1; cfg_bus.cfg_inc = 16'h6000;
        step();  // n=1: transfer
        cfg_bus.cfg_valid = 1'b0;
        cnt = 0;
        // Phases 6000,C000,2000*,8000,E000,4000*,A000,0000* repeating.
        for (int m = 1; m <= 16; m++) begin
            step();
            cnt += int'(tick[1]);
            checks++;
            if (tick[1] !== (m % 8 == 3 || m % 8 == 6 || m % 8 == 0)) begin
                errors++;
                $display("FAIL inc6000 m=%0d: tick1=%b expected %b", m, tick[1],
                         (m % 8 == 3 || m % 8 == 6 || m % 8 == 0));
            end
        end
        checks++;
        if (cnt !== 6) begin
            errors++;
            $display("FAIL inc6000_count: got %0d expected 6", cnt);
        end
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_inc = 16'h0;
        step();
        cfg_bus.cfg_valid = 1'b0;
        cnt = 0;
        for (int m = 1; m <= 20; m++) begin
            step();
            cnt += int'(tick[1]);
        end
        checks++;
        if (cnt !== 0) begin
            errors++;
            $display("FAIL inc0_count: got %0d expected 0", cnt);
        end
    endtask

    task automatic test_bad_ch();
        relock();
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_ch = 4'd5; cfg_bus.cfg_inc = 16'h1234;
        step();  // n=1
        cfg_bus.cfg_valid = 1'b0;
        checks++;
        if ({cfg_bus.cfg_err, cfg_bus.cfg_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bad_ch_pulse: err/ready=%b expected 10",
                     {cfg_bus.cfg_err, cfg_bus.cfg_ready});
        end
        for (int n = 2; n <= 9; n++) begin
            step();
            checks++;
            if ({cfg_bus.cfg_err, tick} !== {1'b0, {2{n % 2 == 0}}}) begin
                errors++;
                $display("FAIL bad_ch_after n=%0d: err/tick=%b expected %b", n,
                         {cfg_bus.cfg_err, tick}, {1'b0, {2{n % 2 == 0}}});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] rdy;
        relock();
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_ch = 4'd0; cfg_bus.cfg_inc = 16'h1000;
        rdy = '0;
        for (int n = 1; n <= 6; n++) begin
            step();
            rdy[n-1] = cfg_bus.cfg_ready;
            // Present the next queued word only after a transfer has been taken.
            if (n == 1) cfg_bus.cfg_inc = 16'h2000;
            if (n == 3) cfg_bus.cfg_inc = 16'h3000;
            if (n == 5) cfg_bus.cfg_valid = 1'b0;
        end
        checks++;
        if (rdy !== 6'b101010) begin
            errors++;
            $display("FAIL b2b_ready: got %b expected 101010 (n6..n1)", rdy);
        end
        // Last transfer at n=5 loaded 3000: first carry 6 adds later (n=11).
        for (int n = 7; n <= 12; n++) begin
            step();
            checks++;
            if (tick !== {n % 2 == 0, n == 11}) begin
                errors++;
                $display("FAIL b2b_rate n=%0d: tick=%b expected %b", n, tick, {n % 2 == 0, n == 11});
            end
        end
    endtask

    task automatic test_disable_reset();
        relock();
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_ch = 4'd1; cfg_bus.cfg_inc = 16'h4000;
        step();  // n=1: ch1 -> 4000, ticks at n=5,9,...
        cfg_bus.cfg_valid = 1'b0;
        repeat (2) step();  // n=3: acc0=8000, div0=1
        ch_en = 2'b10;
        for (int n = 4; n <= 8; n++) begin
            step();
            checks++;
            if ({tick, clk_div[0]} !== {n % 4 == 1, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL disabled n=%0d: tick/div0=%b expected %b", n, {tick, clk_div[0]},
                         {n % 4 == 1, 1'b0, 1'b1});
            end
        end
        ch_en = 2'b11;
        step();  // n=9: held 8000 + 8000 wraps
        checks++;
        if ({tick, clk_div[0]} !== 3'b110) begin
            errors++;
            $display("FAIL resume: tick/div0=%b expected 110", {tick, clk_div[0]});
        end
        rst = 1'b1;
        step();
        checks++;
        if ({locked, tick, clk_div, cfg_bus.cfg_ready} !== 6'b0) begin
            errors++;
            $display("FAIL midrun_reset: got %b expected 000000",
                     {locked, tick, clk_div, cfg_bus.cfg_ready});
        end
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if ({locked, tick} !== {k == 16, 2'b00}) begin
                errors++;
                $display("FAIL relock k=%0d: locked/tick=%b expected %b", k, {locked, tick},
                         {k == 16, 2'b00});
            end
        end
        // Increment of ch1 reverted to 8000.
        for (int n = 1; n <= 6; n++) begin
            step();
            checks++;
            if (tick !== {2{n % 2 == 0}}) begin
                errors++;
                $display("FAIL reverted_inc n=%0d: tick=%b expected %b", n, tick, {2{n % 2 == 0}});
            end
        end
    endtask

    initial begin
        test_reset();
        test_cfg_rate();
        test_fraction();
        test_bad_ch();
        test_back_to_back();
        test_disable_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
